mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have no parameters; all widths SHALL be fixed at 32 bits.
REQ-002 Clk  input  1  single clock; all state SHALL change on the rising edge.
REQ-003 Rst_n  input  1  asynchronous, active-low reset.
REQ-004 Start  input  1  request to begin the operation given by Op, using operands inA and inB.
REQ-005 Op  input  2  operation select: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-006 inA  input  32  multiplicand or dividend (rs); also the data for MtHi and MtLo.
REQ-007 inB  input  32  multiplier or divisor (rt).
REQ-008 MtHi  input  1  write inA into Hi.
REQ-009 MtLo  input  1  write inA into Lo.
REQ-010 Busy  output  1  operation in progress; the pipeline stalls on any HI/LO access while this is high.
REQ-011 Done  output  1  one-cycle pulse; Hi and Lo hold the new result.
REQ-012 DivByZero  output  1  qualifies Done; high when a DIV or DIVU had inB = 0.
REQ-013 Hi  output  32  HI register; drives the writeback 4-to-1 mux.
REQ-014 Lo  output  32  LO register; drives the writeback 4-to-1 mux.

Function
REQ-015 The FSM SHALL have four states: IDLE, RUN, FIX, DONE.
  - Busy = 1 in RUN and FIX.
  - Done = 1 in DONE only.
REQ-016 Start SHALL be accepted only when Busy = 0 (IDLE or DONE).
  - At the accepting edge E0, the block SHALL latch Op, magnitude(inA), magnitude(inB) and the result sign(s), clear the 5-bit iteration counter, and enter RUN.
  - For Op 01 and 11, magnitude = raw value.
REQ-017 RUN SHALL perform one shift-add (multiply) or one restoring subtract-shift (divide) step per cycle, on edges E1..E32.
  - Counter increments each step.
  - The FSM SHALL enter FIX at E32, when the counter wraps from 31 to 0.
REQ-018 At E33 (FIX->DONE), the block SHALL apply sign correction and load Hi/Lo:
  - Multiply: {Hi,Lo} = 64-bit product.
  - Divide: Lo = quotient, Hi = remainder.
REQ-019 DONE SHALL last exactly one cycle (E33..E34) and SHALL then go to IDLE, unless a Start accepted at E34 moves it to RUN.
REQ-020 Signed multiply SHALL negate the 64-bit magnitude product when the operand signs differ.
REQ-021 Signed divide SHALL truncate toward zero.
  - Quotient is negative when the operand signs differ.
  - Remainder takes the sign of the dividend.
REQ-022 DIV 0x80000000 / 0xFFFFFFFF SHALL give Lo = 0x80000000 and Hi = 0, with no error flag.
REQ-023 Divide by zero (DIV or DIVU) SHALL run the full 34-cycle sequence and produce:
  - Lo = 0xFFFFFFFF, Hi = inA (raw), DivByZero = 1 during DONE.
REQ-024 DivByZero SHALL be 0 whenever Done = 0.
REQ-025 When Busy = 0 and Start = 0, MtHi and MtLo SHALL load inA into Hi or Lo at the next edge; both may be asserted together.
REQ-026 MtHi and MtLo SHALL be ignored while Busy = 1, and also in any cycle where Start is accepted (Start wins).
REQ-027 Start while Busy = 1 SHALL be ignored, with no queueing, and Op/operands SHALL remain unchanged.
REQ-028 Hi and Lo SHALL hold their values in every cycle that is neither the FIX->DONE edge nor a permitted MtHi/MtLo write.
REQ-029 Hi and Lo SHALL keep their previous values throughout RUN and FIX.

Reset
REQ-030 Rst_n = 0 SHALL immediately, without waiting for Clk, force:
  - state = IDLE, counter = 0;
  - Busy = 0, Done = 0, DivByZero = 0;
  - Hi = 0, Lo = 0;
  - all internal operand registers = 0.
REQ-031 Reset asserted mid-operation SHALL abort it with no partial Hi/Lo update.
REQ-032 The first edge after Rst_n rises SHALL be able to accept a Start.

Verification
REQ-033 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> Busy high from E0+ to E33, Done one cycle after E33, Hi = 0xFFFFFFFE, Lo = 0x00000001.
REQ-034 MULT 0xFFFFFFFE x 0x00000003 -> Hi = 0xFFFFFFFF, Lo = 0xFFFFFFFA; then DIV 0x80000000 / 0xFFFFFFFF -> Lo = 0x80000000, Hi = 0, DivByZero = 0.
REQ-035 DIV 0xFFFFFFF9 / 0x00000002 -> Lo = 0xFFFFFFFD, Hi = 0xFFFFFFFF; DIVU 0x00000064 / 0x00000007 -> Lo = 0x0000000E, Hi = 0x00000002.
REQ-036 DIVU 0x00000064 / 0 -> Done and DivByZero high together for one cycle, Hi = 0x00000064, Lo = 0xFFFFFFFF.
REQ-037 While Busy: Start with new operands at cycle 10 and MtHi = 1 -> both ignored, original result intact. Afterwards: MtLo with inA = 0x12345678 -> Lo = 0x12345678, Hi unchanged; Start + MtHi in the same cycle -> operation starts, Hi not written.
REQ-038 Rst_n pulsed low mid-edge at cycle 15 of a DIV -> Busy, Hi and Lo are 0 before the next edge; a MULTU 3 x 5 issued after release -> Lo = 0x0000000F, Hi = 0.

Source files
------------

// File: rtl/mult_div_unit.sv
// 32-bit multiply/divide unit: shift-add multiply and restoring divide over 32 iterations,
// then a sign-correction step that loads HI/LO.
module mult_div_unit (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Start,
    input  logic [1:0]  Op,
    input  logic [31:0] inA,
    input  logic [31:0] inB,
    input  logic        MtHi,
    input  logic        MtLo,
    output logic        Busy,
    output logic        Done,
    output logic        DivByZero,
    output logic [31:0] Hi,
    output logic [31:0] Lo
);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [4:0]  r_cnt;
    logic        r_is_div;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_div0;
    logic [31:0] r_opnd;
    logic [63:0] r_acc;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_accept;
    logic        w_neg_a;
    logic        w_neg_b;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [32:0] w_mul_sum;
    logic [32:0] w_div_diff;
    logic [63:0] w_acc_step;
    logic [63:0] w_prod;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    // NOTE: the state register uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // NOTE: outputs and next state get defaults first so no path through the case infers a latch.
    always_comb begin
        w_next = r_state;
        Busy   = 1'b0;
        Done   = 1'b0;
        case (r_state)
            IDLE: if (Start) w_next = RUN;
            RUN: begin
                Busy = 1'b1;
                if (r_cnt == 5'd31) w_next = FIX;
            end
            FIX: begin
                Busy   = 1'b1;
                w_next = DONE;
            end
            DONE: begin
                Done   = 1'b1;
                w_next = Start ? RUN : IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_accept  = Start & ~Busy;
    assign DivByZero = Done & r_div0;
    assign Hi        = r_hi;
    assign Lo        = r_lo;

    // Op[0] = 0 selects the signed variants.
    assign w_neg_a = ~Op[0] & inA[31];
    assign w_neg_b = ~Op[0] & inB[31];
    assign w_mag_a = w_neg_a ? (32'd0 - inA) : inA;
    assign w_mag_b = w_neg_b ? (32'd0 - inB) : inB;

    // Multiply keeps {partial, multiplier}; divide keeps {remainder, dividend/quotient}.
    assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);
    assign w_div_diff = r_acc[63:31] - {1'b0, r_opnd};
    assign w_acc_step = !r_is_div     ? {w_mul_sum, r_acc[31:1]} :
                        w_div_diff[32] ? {r_acc[62:0], 1'b0} :
                                         {w_div_diff[31:0], r_acc[30:0], 1'b1};

    assign w_prod = r_neg_q ? (64'd0 - r_acc) : r_acc;
    assign w_quot = r_neg_q ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
    assign w_rem  = r_neg_r ? (32'd0 - r_acc[63:32]) : r_acc[63:32];

    // NOTE: every datapath register, HI/LO included, clears on reset so an aborted operation leaves nothing behind.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_cnt    <= 5'd0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_opnd   <= 32'd0;
            r_acc    <= 64'd0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
        end else begin
            if (w_accept) begin
                r_is_div <= Op[1];
                r_neg_q  <= w_neg_a ^ w_neg_b;
                r_neg_r  <= w_neg_a;
                r_div0   <= Op[1] & (inB == 32'd0);
                r_opnd   <= Op[1] ? w_mag_b : w_mag_a;
                r_acc    <= {32'd0, Op[1] ? w_mag_a : w_mag_b};
                r_cnt    <= 5'd0;
            end else if (r_state == RUN) begin
                r_acc <= w_acc_step;
                r_cnt <= r_cnt + 5'd1;
            end

            // A zero divisor leaves remainder = |dividend|, so sign correction restores raw inA.
            if (r_state == FIX) begin
                if (r_is_div) begin
                    r_lo <= r_div0 ? 32'hFFFF_FFFF : w_quot;
                    r_hi <= w_rem;
                end else begin
                    {r_hi, r_lo} <= w_prod;
                end
            end else if (!Busy && !Start) begin
                if (MtHi) r_hi <= inA;
                if (MtLo) r_lo <= inA;
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, randomized ops against
// an arithmetic reference model, and hand-written sequences for stall, MtHi/MtLo and reset.
module tb_mult_div_unit;

    logic        Clk;
    logic        Rst_n;
    logic        Start;
    logic [1:0]  Op;
    logic [31:0] inA;
    logic [31:0] inB;
    logic        MtHi;
    logic        MtLo;
    logic        Busy;
    logic        Done;
    logic        DivByZero;
    logic [31:0] Hi;
    logic [31:0] Lo;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    vec_t vecs [9];

    mult_div_unit dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .Start     (Start),
        .Op        (Op),
        .inA       (inA),
        .inB       (inB),
        .MtHi      (MtHi),
        .MtLo      (MtLo),
        .Busy      (Busy),
        .Done      (Done),
        .DivByZero (DivByZero),
        .Hi        (Hi),
        .Lo        (Lo)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: {DivByZero, Hi, Lo} from plain integer arithmetic.
    function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            2'b00: begin p = sa * sb; return {1'b0, p}; end
            2'b01: begin p = ua * ub; return {1'b0, p}; end
            default: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
                if (op == 2'b10) begin q = sa / sb; r = sa % sb; end
                else             begin q = ua / ub; r = ua % ub; end
                return {1'b0, r[31:0], q[31:0]};
            end
        endcase
    endfunction

    // Called just after a falling edge; Start is sampled at the next rising edge (E0).
    // Checks Busy/HI/LO hold over E0..E33 and Done at the 34th falling edge.
    task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo, input logic exp_dz,
                         input bit inject);
        logic [31:0] hi0;
        logic [31:0] lo0;
        bit          hold_ok;
        int          lat;
        hi0   = Hi;
        lo0   = Lo;
        Op    = op;
        inA   = a;
        inB   = b;
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        MtHi  = 1'b0;
        Op    = 2'($urandom);
        inA   = $urandom;
        inB   = $urandom;
        check({tag, "_first_cycle"}, {61'd0, Busy, Done, DivByZero}, 64'b100);
        lat     = 1;
        hold_ok = 1'b1;
        while (!Done && lat < 40) begin
            if (!Busy || Hi !== hi0 || Lo !== lo0) hold_ok = 1'b0;
            if (inject && lat == 10) begin
                Start = 1'b1;
                MtHi  = 1'b1;
                Op    = 2'b11;
                inA   = 32'hCAFE_F00D;
                inB   = 32'd7;
            end else if (inject && lat == 11) begin
                Start = 1'b0;
                MtHi  = 1'b0;
            end
            @(negedge Clk);
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'd34);
        check({tag, "_busy_hold"}, {63'd0, hold_ok}, 64'd1);
        check({tag, "_busy_at_done"}, {63'd0, Busy}, 64'd0);
        check({tag, "_hi"}, {32'd0, Hi}, {32'd0, exp_hi});
        check({tag, "_lo"}, {32'd0, Lo}, {32'd0, exp_lo});
        check({tag, "_dz"}, {63'd0, DivByZero}, {63'd0, exp_dz});
    endtask

    initial begin
        logic [64:0] m;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        vecs[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[1] = '{2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0};
        vecs[2] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        vecs[3] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[4] = '{2'b11, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0};
        vecs[5] = '{2'b11, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1};
        vecs[6] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
        vecs[7] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
        vecs[8] = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};

        Rst_n = 1'b1;
        Start = 1'b0;
        Op    = 2'b00;
        inA   = 32'd0;
        inB   = 32'd0;
        MtHi  = 1'b0;
        MtLo  = 1'b0;
        #1 Rst_n = 1'b0;
        #1;
        check("reset_flags", {61'd0, Busy, Done, DivByZero}, 64'd0);
        check("reset_hilo", {Hi, Lo}, 64'd0);
        @(negedge Clk);
        @(negedge Clk);
        Rst_n = 1'b1;

        // Back-to-back: each op is started during the previous op's DONE cycle.
        for (int i = 0; i < 9; i++)
            do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                  vecs[i].hi, vecs[i].lo, vecs[i].dz, 1'b0);

        for (int i = 0; i < 24; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 9));
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            m = model(rop, ra, rb);
            do_op($sformatf("rnd%0d", i), rop, ra, rb, m[63:32], m[31:0], m[64], 1'b0);
        end

        // Start and MtHi during Busy are ignored; the original product survives.
        do_op("stall", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b1);
        @(negedge Clk);
        check("done_one_cycle", {62'd0, Done, DivByZero}, 64'd0);
        MtLo = 1'b1;
        inA  = 32'h1234_5678;
        @(negedge Clk);
        MtLo = 1'b0;
        check("mtlo_lo", {32'd0, Lo}, 64'h1234_5678);
        check("mtlo_hi_kept", {32'd0, Hi}, 64'hFFFF_FFFE);
        MtHi = 1'b1;
        do_op("start_wins", 2'b01, 32'h0000_0011, 32'h0000_0003, 32'h0000_0000, 32'h0000_0033, 1'b0, 1'b0);
        @(negedge Clk);
        MtHi = 1'b1;
        MtLo = 1'b1;
        inA  = 32'hA5A5_0F0F;
        @(negedge Clk);
        MtHi = 1'b0;
        MtLo = 1'b0;
        check("mthi_mtlo_both", {Hi, Lo}, 64'hA5A5_0F0F_A5A5_0F0F);

        // Reset pulse mid-divide clears everything before the next edge.
        Op    = 2'b10;
        inA   = 32'hFFFF_FF00;
        inB   = 32'd5;
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        repeat (14) @(negedge Clk);
        check("pre_reset_busy", {63'd0, Busy}, 64'd1);
        #1 Rst_n = 1'b0;
        #1;
        check("midreset_busy", {63'd0, Busy}, 64'd0);
        check("midreset_hilo", {Hi, Lo}, 64'd0);
        #1 Rst_n = 1'b1;
        @(negedge Clk);
        check("post_reset_idle", {62'd0, Busy, Done}, 64'd0);
        do_op("after_reset", 2'b01, 32'd3, 32'd5, 32'd0, 32'h0000_000F, 1'b0, 1'b0);

        @(negedge Clk);
        check("final_done_low", {63'd0, Done}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
